f1_random_delay: RTL and testbench

Randomised hold timer for the F1 start-light controller. It sits between the light-sequence FSM and the "lights out" event. A 16-bit LFSR free-runs while the FSM holds `en_lfsr` high. On the FSM's one-cycle `start_delay` pulse, the block samples the LFSR to pick a hold time in milliseconds, counts it down on the 1 ms `tick_ms` strobe, and returns a single-cycle `time_out` pulse that sends the FSM back to IDLE (all lights out).

---
 rtl/f1_random_delay.sv | 102 ++++++++++
 tb/tb_f1_random_delay.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/f1_random_delay.sv
// Randomised hold timer for the F1 start lights: a free-running LFSR picks a hold
// length on start_delay, which is counted down on tick_ms and ends in a time_out pulse.
module f1_random_delay #(
  parameter int unsigned        LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]  SEED       = 16'hACE1,
  parameter int unsigned        MIN_MS     = 250,
  parameter int unsigned        RANGE_BITS = 11,
  parameter int unsigned        CNT_W      = 12
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             tick_ms,
  input  logic             en_lfsr,
  input  logic             start_delay,
  input  logic             abort,
  output logic             time_out,
  output logic             busy,
  output logic [CNT_W-1:0] delay_ms,
  output logic [CNT_W-1:0] remaining_ms
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   delay_q, delay_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               time_out_q, time_out_d;
  logic               fb;
  logic [CNT_W-1:0]   target;

  // Taps for x^16+x^14+x^13+x^11+1; only the 16-bit polynomial is implemented.
  assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign target = CNT_W'(MIN_MS) + CNT_W'(lfsr_q[RANGE_BITS-1:0]);

  always_comb begin
    lfsr_d = lfsr_q;
    // An all-zero register is a lock-up state; recover even while stepping is disabled.
    if (lfsr_q == '0) begin
      lfsr_d = SEED;
    end else if (en_lfsr) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
    end
  end

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    remaining_d = remaining_q;
    case (state_q)
      StIdle: begin
        if (start_delay) begin
          state_d     = StRun;
          delay_d     = target;
          remaining_d = target;
        end
      end
      StRun: begin
        if (abort) begin
          state_d     = StIdle;
          remaining_d = '0;
        end else if (tick_ms) begin
          if (remaining_q > CNT_W'(1)) begin
            remaining_d = remaining_q - CNT_W'(1);
          end else begin
            remaining_d = '0;
            state_d     = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    time_out_d = (state_d == StDone);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lfsr_q      <= SEED;
      delay_q     <= '0;
      remaining_q <= '0;
      time_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      delay_q     <= delay_d;
      remaining_q <= remaining_d;
      time_out_q  <= time_out_d;
    end
  end

  assign time_out     = time_out_q;
  assign busy         = (state_q != StIdle);
  assign delay_ms     = delay_q;
  assign remaining_ms = remaining_q;

endmodule

// File: tb/tb_f1_random_delay.sv
// Bench for f1_random_delay: directed scenarios plus random traffic against a
// cycle-level reference model, with a time_out scoreboard checked by a separate monitor.
`timescale 1ns/1ps
module tb_f1_random_delay;

  logic        sysclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_ms = 1'b0;
  logic        en_lfsr = 1'b0;
  logic        start_delay = 1'b0;
  logic        abort = 1'b0;
  logic        time_out;
  logic        busy;
  logic [11:0] delay_ms;
  logic [11:0] remaining_ms;

  always #5 sysclk = ~sysclk;

  f1_random_delay dut (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .tick_ms      (tick_ms),
    .en_lfsr      (en_lfsr),
    .start_delay  (start_delay),
    .abort        (abort),
    .time_out     (time_out),
    .busy         (busy),
    .delay_ms     (delay_ms),
    .remaining_ms (remaining_ms)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_to = 0;

  // Reference model state
  int unsigned m_lfsr;
  bit          m_run, m_done;
  int          m_left, m_delay;
  int          sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int unsigned lfsr_next(input int unsigned v);
    int unsigned fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) & 32'hFFFF) | fb;
  endfunction

  task automatic model_reset();
    m_lfsr  = 32'hACE1;
    m_run   = 0;
    m_done  = 0;
    m_left  = 0;
    m_delay = 0;
    sb_q.delete();
  endtask

  task automatic model_edge(input bit st, input bit tk, input bit ab, input bit en);
    int unsigned old;
    old = m_lfsr;
    if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      if (ab) begin
        m_run  = 0;
        m_left = 0;
        if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
      end else if (tk) begin
        if (m_left > 1) m_left--;
        else begin
          m_left = 0;
          m_run  = 0;
          m_done = 1;
        end
      end
    end else if (st) begin
      m_delay = 250 + int'(old & 32'h7FF);
      m_left  = m_delay;
      m_run   = 1;
      sb_q.push_back(m_delay);
    end
    if (old == 0) m_lfsr = 32'hACE1;
    else if (en) m_lfsr = lfsr_next(old);
  endtask

  task automatic check_all();
    chk("busy", int'(busy), int'(m_run | m_done));
    chk("time_out", int'(time_out), int'(m_done));
    chk("delay_ms", int'(delay_ms), m_delay);
    chk("remaining_ms", int'(remaining_ms), m_left);
  endtask

  // Called at a negedge; drives inputs, advances one clock, checks at the next negedge.
  task automatic cyc(input bit st, input bit tk, input bit ab, input bit en);
    start_delay = st;
    tick_ms     = tk;
    abort       = ab;
    en_lfsr     = en;
    @(posedge sysclk);
    model_edge(st, tk, ab, en);
    @(negedge sysclk);
    check_all();
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic reset_async();
    start_delay = 0;
    tick_ms     = 0;
    abort       = 0;
    en_lfsr     = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge sysclk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every time_out must match an outstanding hold
  always @(negedge sysclk) begin
    if (rst_n === 1'b1 && time_out === 1'b1) begin
      n_to++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_time_out", 1, 0);
      end else begin
        chk("sb_delay", int'(delay_ms), sb_q.pop_front());
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin
    int to0;
    model_reset();
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    check_all();

    // Deterministic hold with the LFSR frozen at its seed
    cyc(1, 0, 0, 0);
    chk("det_delay", int'(delay_ms), 1499);
    chk("det_remaining", int'(remaining_ms), 1499);
    to0 = n_to;
    for (int i = 0; i < 1499; i++) cyc(0, 1, 0, 0);
    chk("det_time_out", int'(time_out), 1);
    cyc(0, 1, 0, 0);
    chk("det_busy_fall", int'(busy), 0);
    chk("det_one_pulse", n_to - to0, 1);

    // One LFSR step from reset
    reset_async();
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    chk("lfsr_step_delay", int'(delay_ms), 701);
    cyc(0, 0, 1, 0);

    // Abort after 10 ticks, coincident with a tick
    reset_async();
    cyc(1, 0, 0, 0);
    repeat (10) cyc(0, 1, 0, 0);
    chk("abort_rem_before", int'(remaining_ms), 1489);
    to0 = n_to;
    cyc(0, 1, 1, 0);
    chk("abort_rem", int'(remaining_ms), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_delay_kept", int'(delay_ms), 1499);
    repeat (3) cyc(0, 1, 0, 0);
    chk("abort_no_time_out", n_to - to0, 0);

    // Abort wins even on the last tick
    cyc(1, 0, 0, 0);
    repeat (1498) cyc(0, 1, 0, 0);
    chk("abort_last_rem", int'(remaining_ms), 1);
    to0 = n_to;
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    chk("abort_last_no_time_out", n_to - to0, 0);

    // Re-starts in RUN and DONE are ignored; abort in DONE is ignored too
    reset_async();
    cyc(1, 0, 0, 0);
    repeat (5) cyc(0, 1, 0, 0);
    to0 = n_to;
    cyc(1, 0, 0, 1);
    chk("restart_delay", int'(delay_ms), 1499);
    chk("restart_rem", int'(remaining_ms), 1494);
    for (int i = 0; i < 3000 && m_left > 0; i++) cyc(0, 1, 0, 1);
    chk("restart_in_done", int'(time_out), 1);
    cyc(1, 0, 1, 0);
    chk("restart_idle_after_done", int'(busy), 0);
    chk("restart_one_pulse", n_to - to0, 1);

    // Reset in the middle of a hold
    reset_async();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 2000 && m_left != 700; i++) cyc(0, 1, 0, 0);
    chk("midreset_rem_700", int'(remaining_ms), 700);
    to0 = n_to;
    reset_async();
    chk("midreset_time_out", int'(time_out), 0);
    repeat (3) cyc(0, 1, 0, 0);
    chk("midreset_no_time_out", n_to - to0, 0);
    cyc(1, 0, 0, 0);
    chk("midreset_seed_delay", int'(delay_ms), 1499);
    cyc(0, 0, 1, 0);

    // Start coincident with a tick: load is not decremented
    cyc(1, 1, 0, 0);
    chk("coinc_rem", int'(remaining_ms), 1499);
    cyc(0, 0, 1, 0);

    // Random traffic
    for (int i = 0; i < 30000; i++) begin
      cyc(($urandom % 16) == 0, ($urandom % 2) == 0, ($urandom % 2500) == 0,
          ($urandom % 2) == 0);
    end

    start_delay = 0;
    tick_ms     = 0;
    abort       = 0;
    en_lfsr     = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
